// File: rtl/store_buffer_mem_if_if.sv
// store_buffer_mem_if_if: handshaked data-memory bus between the store buffer (master) and memory (slave).
`default_nettype none
`timescale 1ns/1ps

interface store_buffer_mem_if_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/store_buffer_mem_if.sv
// store_buffer_mem_if: MEM-stage store FIFO with req/ack drain, stalling loads.
// Optional STORE_FORWARD_EN: loads hitting a buffered store retire with forwarded data in 0 cycles.
`default_nettype none
`timescale 1ns/1ps

module store_buffer_mem_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic [AW-1:0]     cpu_addr,
   input  wire logic [DW-1:0]     cpu_wdata,
   input  wire logic              cpu_mem_write,
   input  wire logic              cpu_mem_read,
   output logic [DW-1:0]          cpu_rdata,
   output logic                   cpu_stall,
   store_buffer_mem_if_if.master  mem
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [PW-1:0] PINC  = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_addr_q [DEPTH];
   logic [DW-1:0]   r_data_q [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_rdata;
   logic            r_req;
   logic            r_we;
   logic [AW-1:0]   r_maddr;
   logic [DW-1:0]   r_mwdata;

   logic            w_hit;
   logic            w_enq;
   logic            w_deq;
   logic            w_load;
   logic            w_issue_idle;
   logic            w_issue_ack;

   // A full FIFO refuses the store even on a dequeue edge; it enters one edge later.
   assign w_enq  = cpu_mem_write && (r_count != FULL);
   assign w_deq  = (r_state == S_WR) && mem.ack;
   assign w_load = cpu_mem_read && !w_hit && (r_state != S_DONE);

   assign cpu_stall = (cpu_mem_write && (r_count == FULL)) || w_load;

`ifdef STORE_FORWARD_EN
   logic [DW-1:0] w_fwd;

   // Scan oldest to youngest so the youngest matching store wins.
   always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cpu_mem_read && (CW'(i) < r_count) &&
             (r_addr_q[r_head + PW'(i)][AW-1:2] == cpu_addr[AW-1:2])) begin
            w_hit = 1'b1;
            w_fwd = r_data_q[r_head + PW'(i)];
         end
      end
   end

   assign w_issue_idle = w_load;
   assign w_issue_ack  = w_load;
   assign cpu_rdata    = w_hit ? w_fwd : r_rdata;
`else
   assign w_hit        = 1'b0;
   assign w_issue_idle = w_load && (r_count == '0);
   assign w_issue_ack  = w_load && (r_count == ONE);
   assign cpu_rdata    = r_rdata;
`endif

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr_q[r_tail] <= cpu_addr;
         r_data_q[r_tail] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_rdata  <= '0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + PINC;
         if (w_deq) r_head <= r_head + PINC;
         if (w_enq && !w_deq)      r_count <= r_count + ONE;
         else if (!w_enq && w_deq) r_count <= r_count - ONE;

         case (r_state)
            S_IDLE: begin
               if (w_issue_idle) begin
                  r_state <= S_RD;
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_maddr <= cpu_addr;
               end else if (r_count != '0) begin
                  r_state  <= S_WR;
                  r_req    <= 1'b1;
                  r_we     <= 1'b1;
                  r_maddr  <= r_addr_q[r_head];
                  r_mwdata <= r_data_q[r_head];
               end
            end
            S_WR: begin
               if (mem.ack) begin
                  if (w_issue_ack) begin
                     r_state <= S_RD;
                     r_we    <= 1'b0;
                     r_maddr <= cpu_addr;
                  end else if (r_count > ONE) begin
                     r_maddr  <= r_addr_q[r_head + PINC];
                     r_mwdata <= r_data_q[r_head + PINC];
                  end else begin
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                     r_we    <= 1'b0;
                  end
               end
            end
            S_RD: begin
               if (mem.ack) begin
                  r_rdata <= mem.rdata;
                  r_req   <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem.req   = r_req;
   assign mem.we    = r_we;
   assign mem.addr  = r_maddr;
   assign mem.wdata = r_mwdata;

endmodule

`default_nettype wire
